freq_meter: RTL

- Downstream consumer of the test-signal generator in the frequency counter project.
- Samples the asynchronous square wave `sigin` on `sysclk` and counts its rising edges over a fixed gate window (default 1 s at 50 MHz).
- At the end of each window, latches the count as BCD digits for the 7-segment display stage.
- Runs continuously, back-to-back windows, no dead time.

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 25 ++
 rtl/freq_meter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants, types and helpers for the frequency meter.
// Digit width, decade limit, default gate length and FSM states.
package freq_meter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

  // One second at a 50 MHz system clock
  localparam int DEF_GATE_CYCLES = 50_000_000;

  typedef enum logic {
    RESET_ST,
    RUN
  } state_t;

  function automatic logic [BCD_W-1:0] bcd_inc(
    input logic [BCD_W-1:0] d
  );
    return (d == DIGIT_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the edge counter.
// Wraps 9 -> 0 with carry; holds when the whole count is saturated.
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic             sysclk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             sat,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  always_ff @(posedge sysclk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= bcd_inc(q);
    end
  end

  assign carry_out = inc && (q == DIGIT_MAX);

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter for an asynchronous input.
// Result is latched as BCD at every window close.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int DIGITS      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic                    sigin,
  input  logic                    hold,
  output logic [BCD_W*DIGITS-1:0] freq_bcd,
  output logic                    overflow,
  output logic                    valid,
  output logic                    gate_active
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise;

  logic [GW-1:0] gate_cnt;
  logic          run;
  logic          close;
  logic          inc;

  logic [BCD_W*DIGITS-1:0] count;
  logic [BCD_W*DIGITS-1:0] count_plus;
  logic [BCD_W*DIGITS-1:0] result;
  logic [DIGITS:0]         carry;
  logic [DIGITS-1:0]       is_nine;
  logic                    all_nine;
  logic                    ovf_flag;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= RESET_ST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RESET_ST: state_nxt = RUN;
      RUN:      state_nxt = RUN;
      default:  state_nxt = RESET_ST;
    endcase
  end

  assign run         = (state == RUN);
  assign gate_active = run;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sigin};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      gate_cnt <= '0;
    end else if (run) begin
      gate_cnt <= close ? '0 : gate_cnt + GW'(1);
    end
  end

  assign close = run && (gate_cnt == LAST);
  assign inc   = rise && run;

  assign carry[0] = inc;
  assign all_nine = &is_nine;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .sysclk    (sysclk),
      .reset     (reset),
      .inc       (carry[i]),
      .clr       (close),
      .sat       (all_nine),
      .q         (count[i*BCD_W +: BCD_W]),
      .carry_out (carry[i+1])
    );

    assign is_nine[i] = (count[i*BCD_W +: BCD_W] == DIGIT_MAX);

    assign count_plus[i*BCD_W +: BCD_W] = carry[i]
      ? bcd_inc(count[i*BCD_W +: BCD_W])
      : count[i*BCD_W +: BCD_W];
  end

  // A carry out of the top digit is exactly an edge arriving at all-9s
  assign result = carry[DIGITS] ? count : count_plus;

  always_ff @(posedge sysclk) begin
    if (reset || close) begin
      ovf_flag <= 1'b0;
    end else if (carry[DIGITS]) begin
      ovf_flag <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      freq_bcd <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= close && !hold;
      if (close && !hold) begin
        freq_bcd <= result;
        overflow <= ovf_flag | carry[DIGITS];
      end
    end
  end

endmodule
